// File: rtl/controle_pilha.sv
// Round-robin sequencer in front of the return-address stack (pilha).
// Occupancy is tracked locally so overflow and underflow are rejected before the stack sees a toggle.
module controle_pilha #(
   parameter int PC_WIDTH         = 16,
   parameter int PILHA_WIDTH      = 3,
   parameter int PILHA_CTRL_WIDTH = 2,
   parameter logic [PILHA_CTRL_WIDTH-1:0] PILHA_RESET = 2'b00,
   parameter logic [PILHA_CTRL_WIDTH-1:0] PILHA_PUSH  = 2'b01,
   parameter logic [PILHA_CTRL_WIDTH-1:0] PILHA_POP   = 2'b10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req0,
   input  logic                        req1,
   input  logic [1:0]                  op0,
   input  logic [1:0]                  op1,
   input  logic [PC_WIDTH-1:0]         wdata0,
   input  logic [PC_WIDTH-1:0]         wdata1,
   output logic                        gnt0,
   output logic                        gnt1,
   output logic                        ack0,
   output logic                        ack1,
   output logic [PC_WIDTH-1:0]         rdata,
   output logic                        err,
   output logic [PILHA_WIDTH:0]        depth,
   output logic                        busy,
   output logic                        pilha_active,
   output logic [PILHA_CTRL_WIDTH-1:0] pilha_ctrl,
   output logic [PC_WIDTH-1:0]         pilha_data_in,
   input  logic [PC_WIDTH-1:0]         pilha_data_out,
   input  logic                        pilha_error
);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [PILHA_WIDTH:0] MAX = {1'b0, {PILHA_WIDTH{1'b1}}};
   localparam logic [PILHA_WIDTH:0] ONE = {{PILHA_WIDTH{1'b0}}, 1'b1};

   state_t                        state_q, state_d;
   logic                          last_q, last_d;
   logic                          port_q, port_d;
   logic [1:0]                    op_q, op_d;
   logic [PC_WIDTH-1:0]           wdata_q, wdata_d;
   logic                          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                          ack0_q, ack0_d, ack1_q, ack1_d;
   logic [PC_WIDTH-1:0]           rdata_q, rdata_d;
   logic                          err_q, err_d;
   logic                          reject_q, reject_d;
   logic                          toggled_q, toggled_d;
   logic [PILHA_WIDTH:0]          depth_q, depth_d;
   logic                          active_q, active_d;
   logic [PILHA_CTRL_WIDTH-1:0]   ctrl_q, ctrl_d;
   logic [PC_WIDTH-1:0]           data_in_q, data_in_d;
   logic                          pick;
   logic                          fail;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_INIT;
         last_q    <= 1'b1;
         port_q    <= 1'b0;
         op_q      <= 2'b00;
         wdata_q   <= '0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         reject_q  <= 1'b0;
         toggled_q <= 1'b0;
         depth_q   <= '0;
         active_q  <= 1'b0;
         ctrl_q    <= PILHA_RESET;
         data_in_q <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         port_q    <= port_d;
         op_q      <= op_d;
         wdata_q   <= wdata_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         reject_q  <= reject_d;
         toggled_q <= toggled_d;
         depth_q   <= depth_d;
         active_q  <= active_d;
         ctrl_q    <= ctrl_d;
         data_in_q <= data_in_d;
      end
   end

   // Port 1 wins when alone, or when both request and port 0 was served last.
   assign pick = req1 & (~req0 | ~last_q);
   assign fail = reject_q | (toggled_q & pilha_error);

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      port_d    = port_q;
      op_d      = op_q;
      wdata_d   = wdata_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      rdata_d   = rdata_q;
      err_d     = err_q;
      reject_d  = reject_q;
      toggled_d = toggled_q;
      depth_d   = depth_q;
      active_d  = active_q;
      ctrl_d    = ctrl_q;
      data_in_d = data_in_q;
      case (state_q)
         S_INIT: begin
            active_d = ~active_q;
            ctrl_d   = PILHA_RESET;
            state_d  = S_IDLE;
         end
         S_IDLE: begin
            if (req0 | req1) begin
               port_d  = pick;
               last_d  = pick;
               op_d    = pick ? op1 : op0;
               wdata_d = pick ? wdata1 : wdata0;
               gnt0_d  = ~pick;
               gnt1_d  = pick;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            reject_d  = 1'b0;
            toggled_d = 1'b0;
            case (op_q)
               2'b01: begin
                  if (depth_q == MAX) begin
                     reject_d = 1'b1;
                  end else begin
                     ctrl_d    = PILHA_PUSH;
                     data_in_d = wdata_q;
                     active_d  = ~active_q;
                     toggled_d = 1'b1;
                     rdata_d   = wdata_q;
                  end
               end
               2'b10: begin
                  if (depth_q == '0) begin
                     reject_d = 1'b1;
                  end else begin
                     rdata_d   = pilha_data_out;
                     ctrl_d    = PILHA_POP;
                     active_d  = ~active_q;
                     toggled_d = 1'b1;
                  end
               end
               2'b11: begin
                  ctrl_d    = PILHA_RESET;
                  active_d  = ~active_q;
                  toggled_d = 1'b1;
                  rdata_d   = '0;
               end
               default: reject_d = 1'b1;
            endcase
            state_d = S_WAIT;
         end
         S_WAIT: begin
            err_d = fail;
            if (!fail) begin
               case (op_q)
                  2'b01:   depth_d = depth_q + ONE;
                  2'b10:   depth_d = depth_q - ONE;
                  2'b11:   depth_d = '0;
                  default: depth_d = depth_q;
               endcase
            end
            ack0_d  = ~port_q;
            ack1_d  = port_q;
            state_d = S_RESP;
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_INIT;
      endcase
   end

   assign gnt0          = gnt0_q;
   assign gnt1          = gnt1_q;
   assign ack0          = ack0_q;
   assign ack1          = ack1_q;
   assign rdata         = rdata_q;
   assign err           = err_q;
   assign depth         = depth_q;
   assign busy          = (state_q != S_IDLE);
   assign pilha_active  = active_q;
   assign pilha_ctrl    = ctrl_q;
   assign pilha_data_in = data_in_q;

endmodule

// File: tb/tb_controle_pilha.sv
// Bench for controle_pilha: behavioural stack on the pilha side, table vectors,
// hand-written corner sequences and randomized ops checked against a queue model.
module tb_controle_pilha;

   localparam logic [1:0] C_RST  = 2'b00;
   localparam logic [1:0] C_PUSH = 2'b01;
   localparam logic [1:0] C_POP  = 2'b10;

   logic        clk = 0;
   logic        rst;
   logic        req0, req1;
   logic [1:0]  op0, op1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, ack0, ack1;
   logic [15:0] rdata;
   logic        err;
   logic [3:0]  depth;
   logic        busy;
   logic        pilha_active;
   logic [1:0]  pilha_ctrl;
   logic [15:0] pilha_data_in;
   logic [15:0] pilha_data_out;
   logic        pilha_error;

   int checks = 0;
   int failures = 0;

   controle_pilha dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rdata(rdata), .err(err), .depth(depth), .busy(busy),
      .pilha_active(pilha_active), .pilha_ctrl(pilha_ctrl),
      .pilha_data_in(pilha_data_in), .pilha_data_out(pilha_data_out),
      .pilha_error(pilha_error)
   );

   always #5 clk = ~clk;

   // Behavioural stack: executes one operation per observed toggle of pilha_active.
   logic [15:0] mem [0:7];
   int          sp = 0;
   int          toggle_cnt = 0;
   logic        prev_act = 0;
   logic [1:0]  last_ctrl = 2'b11;

   assign pilha_data_out = (sp > 0) ? mem[sp-1] : 16'h0000;

   always @(posedge clk) begin
      if (rst) begin
         prev_act <= pilha_active;
      end else if (pilha_active != prev_act) begin
         prev_act   <= pilha_active;
         toggle_cnt <= toggle_cnt + 1;
         last_ctrl  <= pilha_ctrl;
         if (!pilha_error) begin
            case (pilha_ctrl)
               C_RST:  sp <= 0;
               C_PUSH: if (sp < 8) begin mem[sp] <= pilha_data_in; sp <= sp + 1; end
               C_POP:  if (sp > 0) sp <= sp - 1;
               default: ;
            endcase
         end
      end
   end

   logic [15:0] mq [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_op(input int port, input logic [1:0] op, input logic [15:0] wd,
                        input bit inj, input logic [15:0] er, input bit ee,
                        input int ed, input int et, input string name);
      int t0;
      int n;
      t0 = toggle_cnt;
      if (port == 0) begin req0 = 1; op0 = op; wdata0 = wd; end
      else           begin req1 = 1; op1 = op; wdata1 = wd; end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((((port == 0) ? gnt0 : gnt1) !== 1'b1) && n < 20);
      if (n >= 20) begin
         chk({name, "_gnt_timeout"}, 32'd0, 32'd1);
         req0 = 0; req1 = 0;
         return;
      end
      chk({name, "_gnt_other"}, {31'd0, (port == 0) ? gnt1 : gnt0}, 32'd0);
      @(negedge clk);
      pilha_error = inj;
      chk({name, "_gnt_pulse"}, {31'd0, gnt0 | gnt1}, 32'd0);
      chk({name, "_early_ack"}, {31'd0, ack0 | ack1}, 32'd0);
      @(negedge clk);
      pilha_error = 0;
      chk({name, "_ack"}, {31'd0, (port == 0) ? ack0 : ack1}, 32'd1);
      chk({name, "_ack_other"}, {31'd0, (port == 0) ? ack1 : ack0}, 32'd0);
      chk({name, "_err"}, {31'd0, err}, {31'd0, ee});
      chk({name, "_depth"}, {28'd0, depth}, ed);
      chk({name, "_toggles"}, toggle_cnt - t0, et);
      if (et == 1) chk({name, "_rdata"}, {16'd0, rdata}, {16'd0, er});
      $display("op %s port=%0d op=%b wdata=%h -> rdata=%h err=%0d depth=%0d", name, port, op, wd, rdata, err, depth);
      req0 = 0; req1 = 0;
      @(negedge clk);
      chk({name, "_ack_pulse"}, {31'd0, ack0 | ack1}, 32'd0);
   endtask

   // Apply one op, deriving expectations from the queue model.
   task automatic model_op(input int port, input logic [1:0] op, input logic [15:0] wd,
                           input bit inj, input string name);
      bit rej;
      bit e;
      logic [15:0] er;
      rej = (op == 2'b00) || (op == 2'b01 && mq.size() == 7) || (op == 2'b10 && mq.size() == 0);
      e   = rej || inj;
      er  = 16'h0;
      if (!rej) begin
         if (op == 2'b01) er = wd;
         else if (op == 2'b10) er = mq[mq.size()-1];
      end
      if (!e) begin
         if (op == 2'b01) mq.push_back(wd);
         else if (op == 2'b10) void'(mq.pop_back());
         else if (op == 2'b11) mq.delete();
      end
      do_op(port, op, wd, inj, er, e, mq.size(), rej ? 0 : 1, name);
   endtask

   typedef struct {
      int          port;
      logic [1:0]  op;
      logic [15:0] wd;
      bit          inj;
      logic [15:0] er;
      bit          ee;
      int          ed;
      int          et;
   } vec_t;

   vec_t tbl [0:16];

   initial begin
      int t0;
      int n;
      int p;
      logic [15:0] nv;

      rst = 1; req0 = 0; req1 = 0; op0 = 0; op1 = 0; wdata0 = 0; wdata1 = 0; pilha_error = 0;

      tbl[0] = '{0, 2'b01, 16'h1234, 0, 16'h1234, 0, 1, 1};
      tbl[1] = '{0, 2'b01, 16'hBEEF, 0, 16'hBEEF, 0, 2, 1};
      tbl[2] = '{0, 2'b10, 16'h0000, 0, 16'hBEEF, 0, 1, 1};
      tbl[3] = '{0, 2'b10, 16'h0000, 0, 16'h1234, 0, 0, 1};
      tbl[4] = '{0, 2'b10, 16'h0000, 0, 16'h0000, 1, 0, 0};
      tbl[5] = '{0, 2'b00, 16'h4321, 0, 16'h0000, 1, 0, 0};
      tbl[6] = '{1, 2'b01, 16'h5555, 1, 16'h5555, 1, 0, 1};
      for (int i = 0; i < 7; i++)
         tbl[7+i] = '{i % 2, 2'b01, 16'h0100 + 16'(i), 0, 16'h0100 + 16'(i), 0, i + 1, 1};
      tbl[14] = '{0, 2'b01, 16'h0999, 0, 16'h0000, 1, 7, 0};
      tbl[15] = '{0, 2'b10, 16'h0000, 0, 16'h0106, 0, 6, 1};
      tbl[16] = '{1, 2'b11, 16'h0000, 0, 16'h0000, 0, 0, 1};

      // Reset state and the single INIT toggle
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_depth", {28'd0, depth}, 32'd0);
      chk("rst_gnt_ack", {28'd0, gnt0, gnt1, ack0, ack1}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_active", {31'd0, pilha_active}, 32'd0);
      chk("rst_ctrl", {30'd0, pilha_ctrl}, {30'd0, C_RST});
      chk("rst_rdata_din", {rdata, pilha_data_in}, 32'd0);
      t0 = toggle_cnt;
      rst = 0;
      @(negedge clk);
      chk("init_busy", {31'd0, busy}, 32'd0);
      repeat (4) @(negedge clk);
      chk("init_toggles", toggle_cnt - t0, 32'd1);
      chk("init_ctrl", {30'd0, last_ctrl}, {30'd0, C_RST});
      chk("init_no_gnt_ack", {28'd0, gnt0, gnt1, ack0, ack1}, 32'd0);
      $display("reset: busy=%0d depth=%0d init_toggles=%0d", busy, depth, toggle_cnt - t0);

      // Table vectors: push/pop, underflow, illegal op, stack error, overflow, flush
      for (int i = 0; i < 17; i++)
         do_op(tbl[i].port, tbl[i].op, tbl[i].wd, tbl[i].inj, tbl[i].er, tbl[i].ee,
               tbl[i].ed, tbl[i].et, $sformatf("vec%0d", i));
      mq.delete();

      // Arbitration: both ports request continuously; last served was port 1
      req0 = 1; op0 = 2'b01; wdata0 = 16'hA000;
      req1 = 1; op1 = 2'b01; wdata1 = 16'hB000;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!(gnt0 | gnt1) && n < 20);
         if (n >= 20) begin
            chk($sformatf("arb%0d_timeout", k), 32'd0, 32'd1);
            break;
         end
         chk($sformatf("arb%0d_single_gnt", k), {31'd0, gnt0 & gnt1}, 32'd0);
         p = gnt1 ? 1 : 0;
         chk($sformatf("arb%0d_order", k), p, k % 2);
         @(negedge clk);
         chk($sformatf("arb%0d_gnt_pulse", k), {31'd0, gnt0 | gnt1}, 32'd0);
         @(negedge clk);
         chk($sformatf("arb%0d_ack", k), {30'd0, ack1, ack0}, (p == 1) ? 32'd2 : 32'd1);
         chk($sformatf("arb%0d_rdata", k), {16'd0, rdata}, {16'd0, (p == 1) ? wdata1 : wdata0});
         mq.push_back((p == 1) ? wdata1 : wdata0);
         chk($sformatf("arb%0d_depth", k), {28'd0, depth}, mq.size());
         $display("arb k=%0d port=%0d rdata=%h depth=%0d", k, p, rdata, depth);
         nv = 16'($urandom);
         if (p == 1) wdata1 = nv; else wdata0 = nv;
      end
      req0 = 0; req1 = 0;
      @(negedge clk);

      // Randomized ops against the queue model
      for (int i = 0; i < 60; i++) begin
         logic [1:0] rop;
         rop = 2'($urandom_range(0, 9) < 4 ? 1 : ($urandom_range(0, 5) == 0 ? 3 : ($urandom_range(0, 7) == 0 ? 0 : 2)));
         model_op($urandom_range(0, 1), rop, 16'($urandom), $urandom_range(0, 9) == 0, $sformatf("rnd%0d", i));
      end

      // Reset during WAIT abandons the op
      req0 = 1; op0 = 2'b01; wdata0 = 16'hAAAA;
      n = 0;
      do begin @(negedge clk); n++; end while (gnt0 !== 1'b1 && n < 20);
      chk("midrst_gnt", {31'd0, gnt0}, 32'd1);
      @(negedge clk);
      rst = 1;
      req0 = 0;
      repeat (2) begin
         @(negedge clk);
         chk("midrst_no_ack", {30'd0, ack0, ack1}, 32'd0);
      end
      chk("midrst_depth", {28'd0, depth}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd1);
      t0 = toggle_cnt;
      rst = 0;
      repeat (4) @(negedge clk);
      chk("midrst_init_toggles", toggle_cnt - t0, 32'd1);
      chk("midrst_init_ctrl", {30'd0, last_ctrl}, {30'd0, C_RST});
      chk("midrst_no_ack_after", {30'd0, ack0, ack1}, 32'd0);
      mq.delete();
      model_op(0, 2'b01, 16'h7777, 0, "midrst_push");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
